fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly downstream of the program counter register. Each cycle it samples the current PC and issues a single-outstanding request to instruction memory. It tags each returned instruction with its PC and buffers it in a small FIFO toward decode. It pulses pc_advance_o so next-PC logic steps the PC, and handles branch flushes by discarding in-flight and buffered instructions.

Parameters:
ADDR_W, 16, PC / instruction-memory address width
INSTR_W, 16, instruction word width
DEPTH, 2, output FIFO entries (power of 2, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
pc_i  input  ADDR_W  current PC from the pc register
pc_advance_o  output  1  next-PC logic steps PC at this edge
flush_i  input  1  redirect: pc register loads target at this edge; discard all fetch state
imem_req_o  output  1  memory request, level
imem_addr_o  output  ADDR_W  request address, stable while imem_req_o=1
imem_ack_i  input  1  response valid; only meaningful while imem_req_o=1
imem_rdata_i  input  INSTR_W  instruction data, valid with imem_ack_i
instr_valid_o  output  1  FIFO head valid
instr_o  output  INSTR_W  FIFO head instruction
instr_pc_o  output  ADDR_W  FIFO head PC tag
instr_ready_i  input  1  decode accepts head when instr_valid_o=1

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, FIFO empty, addr reg=0. Outputs: imem_req_o=0, imem_addr_o=0, pc_advance_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0. Reset mid-request drops the request; the memory side is reset by the same rst_n.
- FSM states: IDLE, REQ, DROP.
- IDLE:
  - flush_i=1: stay IDLE.
  - Else if count<DEPTH: latch addr<=pc_i, go REQ.
  - Else stay IDLE.
- REQ: imem_req_o=1, imem_addr_o=addr.
  - ack & ~flush: push {addr, rdata}, pc_advance_o=1 (combinational, this cycle only), go IDLE.
  - ack & flush: discard data, pc_advance_o=0, go IDLE.
  - ~ack & flush: go DROP.
  - Else hold.
- DROP: imem_req_o=1 with the same addr (the protocol forbids abandoning a request).
  - On ack: discard data, go IDLE. No push, no advance.
  - A flush during DROP has no extra effect.
- pc_advance_o is asserted only in REQ with ack & ~flush. Because the pc register updates at that edge, the following IDLE cycle samples the new pc_i. Same timing after a flush: the redirect target is visible in the IDLE cycle following the flush.
- Throughput: at most one instruction per 2 cycles (IDLE + REQ with zero-wait ack). Memory latency is unbounded.
- FIFO:
  - Push only as above. Pop when instr_valid_o & instr_ready_i.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH. count width = clog2(DEPTH)+1.
  - Full: no new issue, so push never hits a full FIFO. Issue requires count<DEPTH with no outstanding request.
  - Empty: instr_valid_o=0. Head outputs hold their last value; decode must not use them.
- flush_i clears the FIFO (count=0, pointers reset) at that edge and overrides any same-cycle pop or push.
- Head outputs come directly from FIFO storage: no combinational path from imem_rdata_i to instr_o.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, REQ=2'd1, DROP=2'd2), ADDR_W/INSTR_W defaults, and the fetch entry layout {pc, instr}.
- One sub-module: fetch_fifo. Synchronous FIFO, parameters WIDTH and DEPTH, with push, pop, clear, count, head data and async active-low reset. fetch_unit holds the FSM, the address register and pc_advance logic.

Test Plan:
- Reset then release, pc_i=16'h0010, ack 3 cycles after req -> imem_addr_o=16'h0010, one pc_advance_o pulse on the ack cycle, then instr_valid_o=1 with instr_pc_o=16'h0010 and instr_o equal to the rdata.
- Hold instr_ready_i=0, zero-wait ack -> exactly 2 entries are fetched (PCs 0x10, 0x11), imem_req_o stays 0 while full, and pc_advance_o pulses twice. Raise ready -> entries pop in order and issue resumes.
- flush_i in REQ with no ack, ack 2 cycles later with 16'hDEAD -> DROP held with the same address, no push and no advance. The next request uses target pc_i=16'h0040.
- flush_i in the same cycle as ack, with 1 FIFO entry present -> FIFO empties, data is discarded, pc_advance_o=0, and the next state is IDLE.
- FIFO count=1 with pop and push in the same cycle -> count stays 1 and the new head is the pushed entry.
- rst_n asserted mid-REQ -> all outputs go to 0 immediately. After release, fetch restarts from pc_i.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, default widths and
// the layout of a buffered fetch entry.
package fetch_unit_pkg;

   localparam int ADDR_W_DEF  = 16;
   localparam int INSTR_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   // FIFO entry is {pc, instr}; the PC tag occupies the upper bits.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0]  pc;
      logic [INSTR_W_DEF-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries toward decode.
// Clear overrides any same-cycle push or pop.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   input  logic                       i_clear,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   assign w_pop = i_pop && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= r_wptr + PW'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem request from the sampled PC,
// tagged results buffered toward decode, branch flush drains in-flight work.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               pc_advance_o,
   input  logic               flush_i,
   output logic               imem_req_o,
   output logic [ADDR_W-1:0]  imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   input  logic               instr_ready_i
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t              r_state;
   fetch_state_t              w_state_nxt;
   logic [ADDR_W-1:0]         r_addr;
   logic [CW-1:0]             w_count;
   logic [ADDR_W+INSTR_W-1:0] w_head;
   logic                      w_room;
   logic                      w_issue;
   logic                      w_push;
   logic                      w_pop;

   assign w_room  = w_count < CW'(DEPTH);
   assign w_issue = (r_state == IDLE) && !flush_i && w_room;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_issue) w_state_nxt = REQ;
         REQ: begin
            if (imem_ack_i)   w_state_nxt = IDLE;
            else if (flush_i) w_state_nxt = DROP;
         end
         // The bus cannot abandon a request, so a flushed one is waited out.
         DROP:    if (imem_ack_i) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req_o   = (r_state == REQ) || (r_state == DROP);
      pc_advance_o = (r_state == REQ) && imem_ack_i && !flush_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_addr <= '0;
      else if (w_issue) r_addr <= pc_i;
   end

   assign imem_addr_o = r_addr;
   assign w_push      = pc_advance_o;
   assign w_pop       = instr_valid_o && instr_ready_i;

   fetch_fifo #(
      .WIDTH (ADDR_W + INSTR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_din   ({r_addr, imem_rdata_i}),
      .i_pop   (w_pop),
      .i_clear (flush_i),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign instr_valid_o         = (w_count != '0);
   assign {instr_pc_o, instr_o} = w_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level model
// of the fetch contract and a small PC register / memory environment.
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pc_i = '0;
   logic        pc_advance_o;
   logic        flush_i = 1'b0;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [15:0] imem_rdata_i = '0;
   logic        instr_valid_o;
   logic [15:0] instr_o;
   logic [15:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_i          (pc_i),
      .pc_advance_o  (pc_advance_o),
      .flush_i       (flush_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   bit          mon_pop = 0;
   bit          m_busy = 0, m_drop = 0;
   logic [15:0] m_addr = '0;
   logic [15:0] pc_nxt = 16'h0010;
   logic [15:0] flush_tgt = '0;
   int          adv_cnt = 0;

   int          lat = 3, wcnt = 0;
   bit          rand_lat = 0, rand_ready = 0, rand_flush = 0;
   bit          ready_knob = 1, flush_next = 0, flush_on_ack = 0;
   bit          ready_on_ack = 0, force_dead = 0;
   logic [15:0] tgt_knob = '0;
   bit          req_rise = 0, req_prev = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive this cycle's inputs 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk); #1;
      req_rise = imem_req_o && !req_prev;
      req_prev = imem_req_o;
      pc_i = pc_nxt;
      imem_ack_i = 1'b0;
      if (!rst_n || !imem_req_o) wcnt = 0;
      else begin
         if (req_rise && rand_lat) lat = $urandom_range(0, 4);
         if (wcnt >= lat) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = force_dead ? 16'hDEAD : 16'($urandom);
            force_dead   = 0;
            wcnt         = 0;
         end else wcnt++;
      end
      flush_i = flush_next || (flush_on_ack && imem_ack_i) ||
                (rand_flush && ($urandom_range(0, 15) == 0));
      flush_next = 0;
      if (flush_i) flush_tgt = rand_flush ? 16'($urandom) : tgt_knob;
      instr_ready_i = rand_ready   ? 1'($urandom_range(0, 1)) :
                      ready_on_ack ? imem_ack_i : ready_knob;
   endtask

   task automatic wait_rise(input string nm, input int max);
      bit ok = 0;
      for (int i = 0; i < max; i++) begin
         cycle();
         if (req_rise) begin ok = 1; break; end
      end
      chk(nm, 32'(ok), 32'd1);
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, "_req"},   32'(imem_req_o),    32'd0);
      chk({nm, "_addr"},  32'(imem_addr_o),   32'd0);
      chk({nm, "_adv"},   32'(pc_advance_o),  32'd0);
      chk({nm, "_valid"}, 32'(instr_valid_o), 32'd0);
      chk({nm, "_instr"}, 32'(instr_o),       32'd0);
      chk({nm, "_pc"},    32'(instr_pc_o),    32'd0);
   endtask

   // Reference model: one outstanding request, abandoned-by-flush requests
   // complete silently, accepted data enters an in-order buffer of DEPTH.
   always begin : model
      int  occ;
      bit  exp_adv;
      @(negedge clk); #2;
      if (!rst_n) begin
         exp_q.delete();
         m_busy  = 0;
         m_drop  = 0;
         mon_pop = 0;
      end else begin
         chk("req", 32'(imem_req_o), 32'(m_busy));
         if (m_busy) chk("req_addr", 32'(imem_addr_o), 32'(m_addr));
         exp_adv = m_busy && !m_drop && imem_ack_i && !flush_i;
         chk("advance", 32'(pc_advance_o), 32'(exp_adv));
         if (pc_advance_o) adv_cnt++;
         occ = exp_q.size() + (mon_pop ? 1 : 0);
         mon_pop = 0;
         if (flush_i)      exp_q.delete();
         else if (exp_adv) exp_q.push_back({m_addr, imem_rdata_i});
         if (m_busy) begin
            if (imem_ack_i) begin m_busy = 0; m_drop = 0; end
            else if (flush_i) m_drop = 1;
         end else if (!flush_i && occ < DEPTH) begin
            m_busy = 1;
            m_drop = 0;
            m_addr = pc_i;
         end
         if (flush_i)           pc_nxt = flush_tgt;
         else if (pc_advance_o) pc_nxt = pc_i + 16'd1;
         else                   pc_nxt = pc_i;
      end
   end

   always begin : monitor
      logic [31:0] e;
      @(negedge clk);
      if (rst_n) begin
         chk("valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
         if (instr_valid_o && instr_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_empty: got valid head pc %h expected no entry", instr_pc_o);
            end else begin
               e = exp_q.pop_front();
               chk("head_pc",    32'(instr_pc_o), 32'(e[31:16]));
               chk("head_instr", 32'(instr_o),    32'(e[15:0]));
            end
            mon_pop = 1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          adv0;
      bit          found;
      logic [15:0] p, d;

      // Reset state
      pc_nxt = 16'h0010;
      repeat (3) cycle();
      #1;
      check_all_zero("reset");
      cycle();
      rst_n = 1'b1;

      // First fetch with 3-cycle memory latency
      ready_knob = 1; lat = 3;
      wait_rise("t1_req", 20);
      chk("t1_addr", 32'(imem_addr_o), 32'h0010);
      repeat (3) cycle();
      #1;
      chk("t1_adv", 32'(pc_advance_o), 32'd1);
      d = imem_rdata_i;
      cycle(); #1;
      chk("t1_valid", 32'(instr_valid_o), 32'd1);
      chk("t1_pc",    32'(instr_pc_o),    32'h0010);
      chk("t1_instr", 32'(instr_o),       32'(d));

      // Fill with decode stalled
      ready_knob = 0; lat = 0; tgt_knob = 16'h0010; flush_next = 1;
      cycle();
      adv0 = adv_cnt;
      repeat (14) cycle();
      #1;
      chk("t2_adv_count", 32'(adv_cnt - adv0), 32'd2);
      chk("t2_full_req",  32'(imem_req_o),     32'd0);
      chk("t2_valid",     32'(instr_valid_o),  32'd1);
      chk("t2_head_pc",   32'(instr_pc_o),     32'h0010);
      ready_knob = 1;
      repeat (10) cycle();
      chk("t2_resume", 32'(adv_cnt - adv0 > 2), 32'd1);

      // Flush while waiting on memory
      lat = 3; tgt_knob = 16'h0030; flush_next = 1;
      cycle();
      wait_rise("t3_req", 30);
      chk("t3_addr", 32'(imem_addr_o), 32'h0030);
      adv0 = adv_cnt;
      tgt_knob = 16'h0040; flush_next = 1; force_dead = 1;
      cycle();
      for (int i = 0; i < 2; i++) begin
         cycle(); #1;
         chk("t3_drop_req",  32'(imem_req_o),   32'd1);
         chk("t3_drop_addr", 32'(imem_addr_o),  32'h0030);
         chk("t3_drop_adv",  32'(pc_advance_o), 32'd0);
      end
      chk("t3_dead_ack", 32'(imem_ack_i && imem_rdata_i == 16'hDEAD), 32'd1);
      wait_rise("t3_next", 20);
      chk("t3_target",  32'(imem_addr_o),      32'h0040);
      chk("t3_no_push", 32'(adv_cnt - adv0),   32'd0);

      // Flush coinciding with ack, one entry buffered
      ready_knob = 0; lat = 0; tgt_knob = 16'h0050; flush_next = 1;
      cycle();
      found = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(); #1;
         if (pc_advance_o) begin found = 1; break; end
      end
      chk("t4_first_entry", 32'(found), 32'd1);
      flush_on_ack = 1;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (imem_ack_i) begin found = 1; break; end
      end
      #1;
      chk("t4_ack_seen",   32'(found),        32'd1);
      chk("t4_adv_flush",  32'(pc_advance_o), 32'd0);
      flush_on_ack = 0;
      cycle(); #1;
      chk("t4_empty", 32'(instr_valid_o), 32'd0);
      chk("t4_idle",  32'(imem_req_o),    32'd0);

      // Simultaneous push and pop with one entry
      found = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(); #1;
         if (pc_advance_o) begin found = 1; break; end
      end
      chk("t5_first_entry", 32'(found), 32'd1);
      ready_on_ack = 1;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (imem_ack_i) begin found = 1; break; end
      end
      chk("t5_ack_seen", 32'(found), 32'd1);
      p = imem_addr_o; d = imem_rdata_i;
      ready_on_ack = 0;
      cycle(); #1;
      chk("t5_valid", 32'(instr_valid_o), 32'd1);
      chk("t5_pc",    32'(instr_pc_o),    32'(p));
      chk("t5_instr", 32'(instr_o),       32'(d));

      // Asynchronous reset in the middle of a request
      ready_knob = 1; lat = 6; tgt_knob = 16'h0060; flush_next = 1;
      cycle();
      wait_rise("t6_req", 40);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("t6_rst");
      pc_nxt = 16'h0100;
      repeat (2) cycle();
      rst_n = 1'b1;
      wait_rise("t6_restart", 20);
      chk("t6_addr", 32'(imem_addr_o), 32'h0100);

      // Randomized traffic
      rand_lat = 1; rand_ready = 1; rand_flush = 1;
      repeat (3000) cycle();
      rand_flush = 0; rand_ready = 0; rand_lat = 0; ready_knob = 1; lat = 1;
      repeat (20) cycle();

      @(negedge clk); #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
